// File: rtl/ball_paddle_pkg.sv
// Shared constants for the ball/paddle video pipeline: court modes,
// colour width and active screen size.
package ball_paddle_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_TENNIS   = 2'd0;
    localparam mode_t MODE_FOOTBALL = 2'd1;
    localparam mode_t MODE_SQUASH   = 2'd2;
    localparam mode_t MODE_PRACTICE = 2'd3;

    localparam int COLOR_W  = 30;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

endpackage

// File: rtl/mode_scheduler_if.sv
// Scheduler bus: button/menu/timing inputs in, mode/enable/status out.
// master drives the requests and timing, slave is the scheduler.
interface mode_scheduler_if;
    import ball_paddle_pkg::*;

    logic  btn_next;
    logic  cfg_valid;
    mode_t cfg_mode;
    logic  frame_start;
    logic  video_active;
    mode_t mode;
    logic  enable;
    logic  mode_changed;
    logic  busy;

    modport master (
        output btn_next, cfg_valid, cfg_mode,
        output frame_start, video_active,
        input  mode, enable, mode_changed, busy
    );

    modport slave (
        input  btn_next, cfg_valid, cfg_mode,
        input  frame_start, video_active,
        output mode, enable, mode_changed, busy
    );

endinterface

// File: rtl/mode_scheduler_button_debouncer.sv
// Button conditioner: 2-flop sync, hold-time debounce, rising-edge pulse.
// Ports: clk, rst, btn (raw async) -> pulse (one cycle per accepted press).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;
    logic          flip;

    // Level only flips once the mismatch has survived the full hold time.
    assign flip = (sync_b != level) && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            pulse  <= flip && sync_b;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_scheduler.sv
// Court mode scheduler: frame-aligned mode changes with blanking window.
// Ports: clk, rst, bus (slave): requests/timing in, mode/enable/status out.
module mode_scheduler
    import ball_paddle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLANK_FRAMES    = 30,
    parameter int RESET_MODE      = 0
) (
    input logic            clk,
    input logic            rst,
    mode_scheduler_if.slave bus
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam mode_t      RST_MODE   = mode_t'(RESET_MODE);
    localparam logic [7:0] LAST_FRAME = 8'(BLANK_FRAMES - 1);

    logic [1:0] state;
    mode_t      mode_q;
    mode_t      target;
    logic [7:0] frame_cnt;
    logic       deferred;
    logic       changed_q;
    logic       enable_q;
    logic       btn_req;
    logic       req;
    mode_t      req_mode;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .btn  (bus.btn_next),
        .pulse(btn_req)
    );

    // Menu selection outranks the button in the same cycle.
    assign req      = bus.cfg_valid | btn_req;
    assign req_mode = bus.cfg_valid ? bus.cfg_mode : mode_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            mode_q    <= RST_MODE;
            target    <= '0;
            frame_cnt <= '0;
            deferred  <= 1'b0;
            changed_q <= 1'b0;
            enable_q  <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            enable_q  <= bus.video_active && (state == ST_RUN);
            case (state)
                ST_RUN: begin
                    if (req) begin
                        target <= req_mode;
                        state  <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (bus.frame_start) begin
                        mode_q    <= target;
                        changed_q <= 1'b1;
                        frame_cnt <= '0;
                        state     <= ST_BLANK;
                        // A request racing the boundary waits one blank.
                        if (req) begin
                            target   <= req_mode;
                            deferred <= 1'b1;
                        end
                    end else if (req) begin
                        target <= req_mode;
                    end
                end
                ST_BLANK: begin
                    if (req) begin
                        target <= req_mode;
                    end
                    if (bus.frame_start && frame_cnt == LAST_FRAME) begin
                        deferred <= 1'b0;
                        state    <= (deferred || req) ? ST_PEND : ST_RUN;
                    end else begin
                        if (req) begin
                            deferred <= 1'b1;
                        end
                        if (bus.frame_start) begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.mode         = mode_q;
    assign bus.enable       = enable_q;
    assign bus.mode_changed = changed_q;
    assign bus.busy         = (state != ST_RUN);

endmodule
